i2c_slave_ctl: RTL and testbench

I2C target (slave) controller: the responding end of the bus driven by the team's I2C master core. It filters SCL/SDA, detects START/STOP, matches a 7-bit address, receives write bytes, and transmits read bytes. Read data waiting on the host side is covered by clock stretching. It sits between the open-drain pad buffers (iobuf, T = oen) and a host-side byte handshake.

---
 rtl/i2c_slave_ctl_if.sv | 30 +++
 rtl/i2c_slave_ctl.sv | 196 +++++++++++++++++++
 tb/tb_i2c_slave_ctl.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_slave_ctl_if.sv
// rtl/i2c_slave_ctl_if.sv - host handshake and pad signals of the I2C target controller
interface i2c_slave_ctl_if;
    logic       i_enable;
    logic [6:0] i_slave_addr;
    logic [7:0] i_tx_data;
    logic       i_tx_valid;
    logic       o_tx_ready;
    logic [7:0] o_rx_data;
    logic       o_rx_valid;
    logic       o_addr_match;
    logic       o_rw;
    logic       o_stop;
    logic       o_busy;
    logic       i_scl;
    logic       o_scl_oen;
    logic       i_sda;
    logic       o_sda_oen;

    modport slave (
        input  i_enable, i_slave_addr, i_tx_data, i_tx_valid, i_scl, i_sda,
        output o_tx_ready, o_rx_data, o_rx_valid, o_addr_match, o_rw,
               o_stop, o_busy, o_scl_oen, o_sda_oen
    );

    modport master (
        output i_enable, i_slave_addr, i_tx_data, i_tx_valid, i_scl, i_sda,
        input  o_tx_ready, o_rx_data, o_rx_valid, o_addr_match, o_rw,
               o_stop, o_busy, o_scl_oen, o_sda_oen
    );
endinterface

// File: rtl/i2c_slave_ctl.sv
// rtl/i2c_slave_ctl.sv - I2C target: pad filtering, START/STOP, address match, byte rx/tx with stretching
module i2c_slave_ctl #(
    parameter int FILTER_LEN = 3
) (
    input  logic            i_sysclk,
    input  logic            i_reset_n,
    i2c_slave_ctl_if.slave  bus
);
    localparam logic [3:0] FILT_MAX = 4'(FILTER_LEN - 1);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX_LOAD, TX, TX_ACK, IGNORE
    } state_t;

    // index 0 = SCL, index 1 = SDA
    logic [1:0]      sync1, sync2, filt, filt_d;
    logic [1:0][3:0] fcnt;

    state_t     state;
    logic [2:0] bit_cnt;
    logic [6:0] shift;
    logic [6:0] tx_shift;
    logic       ack_drv;
    logic       scl_oen, sda_oen;
    logic       tx_ready, rx_valid, addr_match, stop_p, busy, rw;
    logic [7:0] rx_data;

    logic scl_rise, scl_fall, start_det, stop_det, sda_f;

    // Two-flop synchroniser followed by a run-length filter; idle bus level is 1
    always_ff @(posedge i_sysclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync1  <= 2'b11;
            sync2  <= 2'b11;
            filt   <= 2'b11;
            filt_d <= 2'b11;
            fcnt   <= '0;
        end else begin
            sync1  <= {bus.i_sda, bus.i_scl};
            sync2  <= sync1;
            filt_d <= filt;
            for (int k = 0; k < 2; k++) begin
                if (sync2[k] == filt[k]) begin
                    fcnt[k] <= 4'd0;
                end else if (fcnt[k] == FILT_MAX) begin
                    filt[k] <= sync2[k];
                    fcnt[k] <= 4'd0;
                end else begin
                    fcnt[k] <= fcnt[k] + 4'd1;
                end
            end
        end
    end

    // START/STOP require SCL high on both sides of the SDA edge so a
    // simultaneous SCL fall is never mistaken for a bus condition
    assign sda_f     = filt[1];
    assign scl_rise  =  filt[0] & ~filt_d[0];
    assign scl_fall  = ~filt[0] &  filt_d[0];
    assign start_det =  filt_d[1] & ~filt[1] & filt[0] & filt_d[0];
    assign stop_det  = ~filt_d[1] &  filt[1] & filt[0] & filt_d[0];

    // Protocol FSM with all outputs registered
    always_ff @(posedge i_sysclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= IDLE;
            bit_cnt    <= 3'd0;
            shift      <= 7'd0;
            tx_shift   <= 7'd0;
            ack_drv    <= 1'b0;
            scl_oen    <= 1'b1;
            sda_oen    <= 1'b1;
            tx_ready   <= 1'b0;
            rx_valid   <= 1'b0;
            addr_match <= 1'b0;
            stop_p     <= 1'b0;
            busy       <= 1'b0;
            rw         <= 1'b0;
            rx_data    <= 8'h00;
        end else begin
            tx_ready   <= 1'b0;
            rx_valid   <= 1'b0;
            addr_match <= 1'b0;
            stop_p     <= 1'b0;

            if (start_det)     busy <= 1'b1;
            else if (stop_det) busy <= 1'b0;

            if (!bus.i_enable) begin
                state   <= IDLE;
                scl_oen <= 1'b1;
                sda_oen <= 1'b1;
                bit_cnt <= 3'd0;
                ack_drv <= 1'b0;
            end else if (start_det) begin
                state   <= ADDR;
                bit_cnt <= 3'd0;
                sda_oen <= 1'b1;
                scl_oen <= 1'b1;
                ack_drv <= 1'b0;
            end else if (stop_det) begin
                state   <= IDLE;
                stop_p  <= 1'b1;
                sda_oen <= 1'b1;
                scl_oen <= 1'b1;
                ack_drv <= 1'b0;
            end else begin
                case (state)
                    ADDR: begin
                        if (scl_rise) begin
                            shift   <= {shift[5:0], sda_f};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (shift == bus.i_slave_addr) begin
                                    rw         <= sda_f;
                                    addr_match <= 1'b1;
                                    ack_drv    <= 1'b0;
                                    state      <= ADDR_ACK;
                                end else begin
                                    state <= IGNORE;
                                end
                            end
                        end
                    end
                    ADDR_ACK, RX_ACK: begin
                        // first fall starts the ACK low, second fall ends it
                        if (scl_fall) begin
                            if (!ack_drv) begin
                                sda_oen <= 1'b0;
                                ack_drv <= 1'b1;
                            end else begin
                                sda_oen <= 1'b1;
                                ack_drv <= 1'b0;
                                bit_cnt <= 3'd0;
                                state   <= rw ? TX_LOAD : RX;
                            end
                        end
                    end
                    RX: begin
                        if (scl_rise) begin
                            shift   <= {shift[5:0], sda_f};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                rx_data  <= {shift, sda_f};
                                rx_valid <= 1'b1;
                                ack_drv  <= 1'b0;
                                state    <= RX_ACK;
                            end
                        end
                    end
                    TX_LOAD: begin
                        // SCL release is left to TX so SDA gets a setup cycle
                        if (bus.i_tx_valid) begin
                            tx_shift <= bus.i_tx_data[6:0];
                            sda_oen  <= bus.i_tx_data[7];
                            tx_ready <= 1'b1;
                            bit_cnt  <= 3'd0;
                            state    <= TX;
                        end else begin
                            scl_oen <= 1'b0;
                        end
                    end
                    TX: begin
                        scl_oen <= 1'b1;
                        if (scl_fall) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                sda_oen <= 1'b1;
                                state   <= TX_ACK;
                            end else begin
                                sda_oen  <= tx_shift[6];
                                tx_shift <= {tx_shift[5:0], 1'b0};
                            end
                        end
                    end
                    TX_ACK: begin
                        if (scl_rise && sda_f) state <= IGNORE;
                        else if (scl_fall)     state <= TX_LOAD;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.o_scl_oen    = scl_oen;
    assign bus.o_sda_oen    = sda_oen;
    assign bus.o_tx_ready   = tx_ready;
    assign bus.o_rx_valid   = rx_valid;
    assign bus.o_rx_data    = rx_data;
    assign bus.o_addr_match = addr_match;
    assign bus.o_rw         = rw;
    assign bus.o_stop       = stop_p;
    assign bus.o_busy       = busy;
endmodule

// File: tb/tb_i2c_slave_ctl.sv
// tb/tb_i2c_slave_ctl.sv - self-checking bench for i2c_slave_ctl
`timescale 1ns/1ps
module tb_i2c_slave_ctl;
    localparam int Q = 10;

    logic clk;
    logic rst_n;
    logic m_scl, m_sda;
    int   checks, errors;

    i2c_slave_ctl_if bus();
    i2c_slave_ctl #(.FILTER_LEN(3)) dut (
        .i_sysclk (clk),
        .i_reset_n(rst_n),
        .bus      (bus.slave)
    );

    assign bus.i_scl = m_scl & bus.o_scl_oen;
    assign bus.i_sda = m_sda & bus.o_sda_oen;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // monitor state, written only by the monitor process
    int         match_cnt, rx_cnt, tx_cnt, stop_cnt, drive_cnt, width_err;
    logic       rw_log [64];
    logic [7:0] rx_log [64];
    logic       p_match, p_rx, p_tx, p_stop;

    // read-data provider settings, written only by the main process
    logic [7:0] tx_bytes [8];
    int         tx_base, tx_n;
    logic       tx_en;

    initial begin
        match_cnt = 0; rx_cnt = 0; tx_cnt = 0; stop_cnt = 0;
        drive_cnt = 0; width_err = 0;
        p_match = 0; p_rx = 0; p_tx = 0; p_stop = 0;
        bus.i_tx_valid = 1'b0;
        bus.i_tx_data  = 8'h00;
        forever begin
            int idx;
            @(negedge clk);
            if (bus.o_addr_match) begin rw_log[match_cnt % 64] = bus.o_rw; match_cnt++; end
            if (bus.o_rx_valid)   begin rx_log[rx_cnt % 64] = bus.o_rx_data; rx_cnt++; end
            if (bus.o_tx_ready)   tx_cnt++;
            if (bus.o_stop)       stop_cnt++;
            if (!bus.o_sda_oen)   drive_cnt++;
            if ((bus.o_addr_match && p_match) || (bus.o_rx_valid && p_rx) ||
                (bus.o_tx_ready && p_tx) || (bus.o_stop && p_stop))
                width_err++;
            p_match = bus.o_addr_match; p_rx = bus.o_rx_valid;
            p_tx = bus.o_tx_ready; p_stop = bus.o_stop;
            idx = tx_cnt - tx_base;
            bus.i_tx_valid = tx_en && (idx < tx_n) && (idx >= 0);
            bus.i_tx_data  = (idx >= 0 && idx < 8) ? tx_bytes[idx] : 8'h00;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic raise_scl();
        int n;
        n = 0;
        m_scl = 1'b1;
        while (!bus.i_scl && n < 5000) begin tick(1); n++; end
        checks++;
        if (!bus.i_scl) begin
            errors++;
            $display("FAIL scl_release_timeout: SCL still low after %0d cycles", n);
        end
    endtask

    task automatic m_start();
        m_sda = 1'b1; m_scl = 1'b1; tick(2*Q);
        m_sda = 1'b0; tick(2*Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic m_rstart();
        m_sda = 1'b1; tick(Q);
        raise_scl(); tick(2*Q);
        m_sda = 1'b0; tick(2*Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic m_stop();
        m_sda = 1'b0; tick(Q);
        raise_scl(); tick(2*Q);
        m_sda = 1'b1; tick(2*Q);
    endtask

    task automatic write_bit(input logic b);
        m_sda = b; tick(Q);
        raise_scl(); tick(2*Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic read_bit(output logic b);
        m_sda = 1'b1; tick(Q);
        raise_scl(); tick(Q);
        b = bus.i_sda; tick(Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin read_bit(b); d[i] = b; end
        write_bit(nack);
    endtask

    typedef struct {
        logic [7:0] addr_byte;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [6:0] own;
        logic       exp_nack;
        int         exp_rx;
    } wvec_t;

    wvec_t vec [4];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       a, a0, a1;
        logic [7:0] d;
        logic [7:0] ab;
        int m0, r0, s0, dr0, t0, bad, t_rdy, t_rel;
        logic sda_at;

        checks = 0; errors = 0;
        vec[0] = '{8'hA0, 8'hA5, 8'h3C, 7'h50, 1'b0, 2};
        vec[1] = '{8'hA2, 8'hFF, 8'hFF, 7'h50, 1'b1, 0};
        vec[2] = '{8'hE4, 8'h00, 8'hFF, 7'h72, 1'b0, 2};
        vec[3] = '{8'hA0, 8'h80, 8'h01, 7'h51, 1'b1, 0};

        tx_en = 1'b0; tx_n = 0; tx_base = 0;
        for (int i = 0; i < 8; i++) tx_bytes[i] = 8'h00;
        m_scl = 1'b1; m_sda = 1'b1;
        bus.i_enable = 1'b1;
        bus.i_slave_addr = 7'h50;
        rst_n = 1'b0;
        tick(5);
        check("reset_scl_oen", bus.o_scl_oen, 1);
        check("reset_sda_oen", bus.o_sda_oen, 1);
        check("reset_rx_data", bus.o_rx_data, 8'h00);
        check("reset_rw", bus.o_rw, 0);
        check("reset_busy", bus.o_busy, 0);
        check("reset_pulses", {bus.o_tx_ready, bus.o_rx_valid, bus.o_addr_match, bus.o_stop}, 0);
        rst_n = 1'b1;
        tick(10);

        // table-driven write transfers
        for (int i = 0; i < 4; i++) begin
            bus.i_slave_addr = vec[i].own;
            m0 = match_cnt; r0 = rx_cnt; s0 = stop_cnt; dr0 = drive_cnt;
            m_start();
            check($sformatf("v%0d_busy_set", i), bus.o_busy, 1);
            write_byte(vec[i].addr_byte, a);
            write_byte(vec[i].d0, a0);
            write_byte(vec[i].d1, a1);
            m_stop();
            check($sformatf("v%0d_ack_addr", i), a, vec[i].exp_nack);
            check($sformatf("v%0d_ack_d0", i), a0, vec[i].exp_nack);
            check($sformatf("v%0d_ack_d1", i), a1, vec[i].exp_nack);
            check($sformatf("v%0d_match_cnt", i), match_cnt - m0, vec[i].exp_nack ? 0 : 1);
            check($sformatf("v%0d_rx_cnt", i), rx_cnt - r0, vec[i].exp_rx);
            check($sformatf("v%0d_stop_cnt", i), stop_cnt - s0, 1);
            check($sformatf("v%0d_busy_clr", i), bus.o_busy, 0);
            if (vec[i].exp_rx == 2) begin
                check($sformatf("v%0d_rx0", i), rx_log[r0 % 64], vec[i].d0);
                check($sformatf("v%0d_rx1", i), rx_log[(r0 + 1) % 64], vec[i].d1);
                check($sformatf("v%0d_rw", i), rw_log[m0 % 64], 0);
            end else begin
                check($sformatf("v%0d_no_drive", i), drive_cnt - dr0, 0);
            end
            tick(20);
        end
        bus.i_slave_addr = 7'h50;

        // read: ACK 0x96, NACK 0x01
        tx_bytes[0] = 8'h96; tx_bytes[1] = 8'h01; tx_n = 2; tx_base = tx_cnt; tx_en = 1'b1;
        t0 = tx_cnt; m0 = match_cnt;
        m_start();
        write_byte(8'hA1, a);
        check("rd_addr_ack", a, 0);
        read_byte(d, 1'b0);
        check("rd_byte0", d, 8'h96);
        read_byte(d, 1'b1);
        check("rd_byte1", d, 8'h01);
        check("rd_release", {bus.o_scl_oen, bus.o_sda_oen}, 2'b11);
        m_stop();
        check("rd_tx_ready_cnt", tx_cnt - t0, 2);
        check("rd_rw", rw_log[m0 % 64], 1);
        tx_en = 1'b0;
        tick(20);

        // clock stretch while read data is late
        m_start();
        write_byte(8'hA1, a);
        check("st_addr_ack", a, 0);
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (bus.o_scl_oen !== 1'b0) bad++;
        end
        check("st_held_low", bad, 0);
        tx_bytes[0] = 8'h5A; tx_n = 1; tx_base = tx_cnt; tx_en = 1'b1;
        t_rdy = -1; t_rel = -1; sda_at = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (bus.o_tx_ready && t_rdy < 0) begin t_rdy = i; sda_at = bus.o_sda_oen; end
            if (bus.o_scl_oen && t_rel < 0) t_rel = i;
        end
        check("st_release_delay", t_rel - t_rdy, 1);
        check("st_bit7_setup", sda_at, 0);
        read_byte(d, 1'b1);
        check("st_byte", d, 8'h5A);
        m_stop();
        tx_en = 1'b0;
        tick(20);

        // repeated START: write then read
        tx_bytes[0] = 8'h77; tx_n = 1; tx_base = tx_cnt; tx_en = 1'b1;
        m0 = match_cnt; r0 = rx_cnt; t0 = tx_cnt;
        m_start();
        write_byte(8'hA0, a);  check("sr_addr_w_ack", a, 0);
        write_byte(8'h10, a);  check("sr_data_ack", a, 0);
        m_rstart();
        write_byte(8'hA1, a);  check("sr_addr_r_ack", a, 0);
        read_byte(d, 1'b1);
        m_stop();
        check("sr_read", d, 8'h77);
        check("sr_match_cnt", match_cnt - m0, 2);
        check("sr_rw0", rw_log[m0 % 64], 0);
        check("sr_rw1", rw_log[(m0 + 1) % 64], 1);
        check("sr_rx_cnt", rx_cnt - r0, 1);
        check("sr_rx_data", rx_log[r0 % 64], 8'h10);
        check("sr_tx_cnt", tx_cnt - t0, 1);
        tx_en = 1'b0;
        tick(20);

        // repeated START in the middle of a data byte
        r0 = rx_cnt;
        m_start();
        write_byte(8'hA0, a);
        for (int i = 0; i < 4; i++) write_bit(1'b1);
        m_rstart();
        check("ab_sda_released", bus.o_sda_oen, 1);
        m_stop();
        check("ab_no_rx", rx_cnt - r0, 0);
        tick(20);

        // 2-cycle SCL glitch during a data byte
        r0 = rx_cnt;
        m_start();
        write_byte(8'hA0, a);
        m_sda = 1'b0;
        tick(Q);
        m_scl = 1'b1; tick(2); m_scl = 1'b0;
        tick(Q);
        write_byte(8'hC3, a);
        m_stop();
        check("gl_rx_cnt", rx_cnt - r0, 1);
        check("gl_rx_data", rx_log[r0 % 64], 8'hC3);
        tick(20);

        // disabled core ignores the bus but tracks busy
        bus.i_enable = 1'b0;
        m0 = match_cnt; s0 = stop_cnt;
        m_start();
        check("en_busy_set", bus.o_busy, 1);
        write_byte(8'hA0, a);
        check("en_nack", a, 1);
        m_stop();
        check("en_busy_clr", bus.o_busy, 0);
        check("en_no_pulses", (match_cnt - m0) + (stop_cnt - s0), 0);
        bus.i_enable = 1'b1;
        tick(20);

        // reset asserted while the target drives the address ACK
        m_start();
        ab = 8'hA0;
        for (int i = 7; i >= 0; i--) write_bit(ab[i]);
        m_sda = 1'b1;
        check("rs_ack_driven", bus.o_sda_oen, 0);
        #3 rst_n = 1'b0;
        #1;
        check("rs_async_release", {bus.o_scl_oen, bus.o_sda_oen}, 2'b11);
        tick(3);
        rst_n = 1'b1;
        tick(10);
        m_stop();
        tick(20);
        m0 = match_cnt; r0 = rx_cnt;
        m_start();
        write_byte(8'hA0, a); check("rs_addr_ack", a, 0);
        write_byte(8'h42, a); check("rs_data_ack", a, 0);
        m_stop();
        check("rs_match", match_cnt - m0, 1);
        check("rs_rx_data", rx_log[r0 % 64], 8'h42);

        check("pulse_width", width_err, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
